// File: rtl/serial_word_sched_pkg.sv
// Shared types and default sizing for the serial word scheduler.
package serial_word_sched_pkg;

  // Two-state control FSM: wait for a request, then shift one word out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/serial_word_sched_arb.sv
// Grant selection for the serial word scheduler.
// Define SERIAL_WORD_SCHED_RR_EN for round-robin arbitration; the default
// build uses fixed priority (lowest valid index wins) and ignores pointer.
module serial_word_sched_arb
  import serial_word_sched_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] pointer,
  output logic [NUM_REQ-1:0]         grant
);

  logic found;

`ifdef SERIAL_WORD_SCHED_RR_EN
  // Rotating priority: the first valid index at or after pointer wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req[k] && (k == (int'(pointer) + off) % NUM_REQ)) begin
          grant[k] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`else
  logic pointer_unused;
  assign pointer_unused = ^pointer;

  // Fixed priority: the lowest valid index wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/serial_word_scheduler.sv
// Serial word scheduler: NUM_REQ requesters share one MSB-first shifter.
// A word is accepted in IDLE, shifted out over WIDTH unheld cycles in SHIFT,
// then one IDLE cycle separates it from the next word.
// Define SERIAL_WORD_SCHED_RR_EN for round-robin grant (see the arbiter).
module serial_word_scheduler
  import serial_word_sched_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic                       hold_i,
  output logic                       data_o,
  output logic                       data_val_o,
  output logic [$clog2(NUM_REQ)-1:0] src_o,
  output logic                       busy_o,
  output logic                       word_done_o
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   word_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SRC_W-1:0]   src_q;
  logic [SRC_W-1:0]   ptr_q;
  logic [SRC_W-1:0]   ptr_next;
  logic [SRC_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic               shift_en;
  logic               last_bit;

  serial_word_sched_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req_valid_i),
    .pointer (ptr_q),
    .grant   (grant)
  );

  // Convert the one-hot grant to the winning requester index.
  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) grant_idx = SRC_W'(k);
    end
  end

  // Next search start is the index after the winner, wrapping at NUM_REQ.
  assign ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle control decode.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant != '0) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold_i) begin
          shift_en = 1'b1;
          if (cnt_q == LAST_BIT) begin
            last_bit = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word, bit counter, source index and arbitration pointer.
  // NOTE: the word is a flop vector, not a memory, so it takes the
  // synchronous reset like any other register and an aborted word is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
      src_q  <= '0;
      ptr_q  <= '0;
    end else if (accept) begin
      word_q <= req_data_i[int'(grant_idx)*WIDTH +: WIDTH];
      cnt_q  <= '0;
      src_q  <= grant_idx;
      ptr_q  <= ptr_next;
    end else if (shift_en) begin
      word_q <= {word_q[WIDTH-2:0], 1'b0};
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // Outputs are forced low while reset is asserted, even before the edge.
  assign busy_o      = !rst && (state_q == SHIFT);
  assign req_ready_o = (!rst && (state_q == IDLE)) ? grant : '0;
  assign data_val_o  = busy_o && !hold_i;
  assign data_o      = busy_o && word_q[WIDTH-1];
  assign word_done_o = !rst && last_bit;
  assign src_o       = rst ? '0 : src_q;

endmodule

// File: tb/tb_serial_word_scheduler.sv
// Self-checking bench for serial_word_scheduler (WIDTH=32, NUM_REQ=4).
// Expectations come from a transaction-level model: grant chosen by a
// rotating or fixed search over the valid vector, bits taken MSB-first.
module tb_serial_word_scheduler;

  localparam int W  = 32;
  localparam int NR = 4;
  localparam int SW = 2;
`ifdef SERIAL_WORD_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          hold;
  logic          data;
  logic          data_val;
  logic [SW-1:0] src;
  logic          busy;
  logic          word_done;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] words [NR];
  int mdl_ptr = 0;
  int mdl_src = 0;

  always #5 clk = ~clk;

  serial_word_scheduler #(
    .WIDTH   (W),
    .NUM_REQ (NR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .hold_i      (hold),
    .data_o      (data),
    .data_val_o  (data_val),
    .src_o       (src),
    .busy_o      (busy),
    .word_done_o (word_done)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed outputs {ready, busy, val, data, done, src}; data masked when
  // the bit is not qualified.
  function automatic logic [NR+SW+3:0] obs(input logic mask_data);
    return {req_ready, busy, data_val, (mask_data ? 1'b0 : data), word_done, src};
  endfunction

  // Reference arbitration: first valid index scanning from start.
  function automatic int model_grant(input logic [NR-1:0] v, input int start);
    for (int off = 0; off < NR; off++) begin
      if (v[(start + off) % NR]) return (start + off) % NR;
    end
    return 0;
  endfunction

  function automatic logic [NR-1:0] rand_valid();
    return NR'($urandom_range(1, (1 << NR) - 1));
  endfunction

  // One IDLE cycle presenting v: ready must be the model's one-hot grant.
  task automatic accept_word(input logic [NR-1:0] v, input logic hold_in,
                             input string name, output int g);
    logic [NR-1:0]     oh;
    logic [NR+SW+3:0]  exp_v;
    step();
    rst       = 1'b0;
    req_valid = v;
    hold      = hold_in;
    for (int k = 0; k < NR; k++) req_data[k*W +: W] = words[k];
    #1;
    g      = model_grant(v, RR ? mdl_ptr : 0);
    oh     = '0;
    oh[g]  = 1'b1;
    exp_v  = {oh, 1'b0, 1'b0, 1'b0, 1'b0, SW'(mdl_src)};
    n_cmp++;
    if (obs(1'b0) !== exp_v) begin
      n_err++;
      $display("FAIL %s accept: got=%b exp=%b (ready,busy,val,data,done,src)",
               name, obs(1'b0), exp_v);
    end
    if (RR) mdl_ptr = (g + 1) % NR;
  endtask

  // Follow one word through SHIFT, checking every cycle. Hold is driven
  // for hold_len cycles once hold_at bits have gone out; abort_at >= 0
  // raises rst when that many bits have gone out.
  task automatic expect_word(input int g, input logic [W-1:0] w,
                             input int hold_at, input int hold_len,
                             input logic [NR-1:0] vshift, input int abort_at,
                             input string name);
    int n = 0;
    int held = 0;
    logic [NR+SW+3:0] exp_v;
    logic [NR-1:0] zr = '0;
    while (n < W) begin
      step();
      req_valid = vshift;
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      hold      = (n == hold_at) && (held < hold_len);
      rst       = (n == abort_at);
      #1;
      if (rst)       exp_v = '0;
      else if (hold) exp_v = {zr, 1'b1, 1'b0, 1'b0, 1'b0, SW'(g)};
      else           exp_v = {zr, 1'b1, 1'b1, w[W-1-n], (n == W - 1), SW'(g)};
      n_cmp++;
      if (obs(hold && !rst) !== exp_v) begin
        n_err++;
        $display("FAIL %s bit=%0d hold=%0b rst=%0b: got=%b exp=%b (ready,busy,val,data,done,src)",
                 name, n, hold, rst, obs(hold && !rst), exp_v);
      end
      if (rst) begin
        mdl_ptr = 0;
        mdl_src = 0;
        return;
      end
      if (hold) held++;
      else      n++;
    end
    hold    = 1'b0;
    mdl_src = g;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      rst       = 1'b1;
      req_valid = NR'($urandom);
      hold      = 1'($urandom);
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      n_cmp++;
      if (obs(1'b0) !== '0) begin
        n_err++;
        $display("FAIL reset cycle %0d: got=%b exp=0", i, obs(1'b0));
      end
    end
    mdl_ptr = 0;
    mdl_src = 0;
  endtask

  // Requester 1 valid only in the cycle requester 0 wins: it is not taken.
  task automatic test_drop_not_granted();
    int g;
    foreach (words[k]) words[k] = $urandom;
    accept_word(4'b0011, 1'b0, "drop", g);
    expect_word(g, words[g], -1, 0, '0, -1, "drop_word");
    for (int i = 0; i < 3; i++) begin
      step();
      req_valid = '0;
      #1;
      n_cmp++;
      if (obs(1'b0) !== {{NR{1'b0}}, 4'b0000, SW'(mdl_src)}) begin
        n_err++;
        $display("FAIL idle_after_drop cycle %0d: got=%b exp=%b", i, obs(1'b0),
                 {{NR{1'b0}}, 4'b0000, SW'(mdl_src)});
      end
    end
  endtask

  task automatic test_single_word();
    int g;
    foreach (words[k]) words[k] = $urandom;
    words[2] = 32'hA5A5_0F0F;
    accept_word(4'b0100, 1'b0, "single", g);
    expect_word(2, 32'hA5A5_0F0F, -1, 0, '0, -1, "single_word");
  endtask

  task automatic test_hold();
    int g;
    foreach (words[k]) words[k] = $urandom;
    accept_word(rand_valid(), 1'b0, "hold", g);
    expect_word(g, words[g], 11, 5, '0, -1, "hold_word");
  endtask

  task automatic test_hold_in_idle();
    int g;
    foreach (words[k]) words[k] = $urandom;
    accept_word(rand_valid(), 1'b1, "hold_idle", g);
    expect_word(g, words[g], 0, 1 + int'($urandom % 5), '0, -1, "hold_idle_word");
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 10; i++) begin
      foreach (words[k]) words[k] = $urandom;
      accept_word(rand_valid(), 1'($urandom), "random", g);
      expect_word(g, words[g], int'($urandom % W), int'($urandom % 5),
                  NR'($urandom), -1, "random_word");
    end
  endtask

  task automatic test_reset_mid_word();
    int g;
    foreach (words[k]) words[k] = $urandom;
    accept_word(rand_valid(), 1'b0, "abort", g);
    expect_word(g, words[g], -1, 0, '0, 20, "abort_word");
    foreach (words[k]) words[k] = $urandom;
    accept_word(rand_valid(), 1'b0, "after_abort", g);
    expect_word(g, words[g], -1, 0, '0, -1, "after_abort_word");
  endtask

  task automatic test_back_to_back();
    int g;
    step();
    rst       = 1'b1;
    req_valid = '1;
    #1;
    n_cmp++;
    if (obs(1'b0) !== '0) begin
      n_err++;
      $display("FAIL b2b reset: got=%b exp=0", obs(1'b0));
    end
    mdl_ptr = 0;
    mdl_src = 0;
    foreach (words[k]) words[k] = $urandom;
    for (int i = 0; i < 5; i++) begin
      accept_word('1, 1'b0, "b2b", g);
      expect_word(g, words[g], -1, 0, '1, -1, "b2b_word");
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    hold      = 1'b0;
    test_reset();
    test_drop_not_granted();
    test_single_word();
    test_hold();
    test_hold_in_idle();
    test_random();
    test_reset_mid_word();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
